// File: rtl/xps2_pkg.sv
// Shared definitions for the PS/2 keyboard receiver: register offsets, status bits, FSM states.
package xps2_pkg;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_COUNT  = 2'd2;

  localparam int unsigned ST_NEMPTY = 0;
  localparam int unsigned ST_FULL   = 1;
  localparam int unsigned ST_OVR    = 2;
  localparam int unsigned ST_PERR   = 3;
  localparam int unsigned ST_FERR   = 4;

  localparam logic [7:0] PS2_BREAK_CODE = 8'hF0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } ps2_state_e;

  // Odd parity over eight data bits plus the parity bit.
  function automatic logic odd_parity_ok(input logic [7:0] byte_i, input logic par_i);
    return ^{par_i, byte_i};
  endfunction

endpackage

// File: rtl/xps2_fifo.sv
// Synchronous byte FIFO; a pop on empty is ignored, a push on full succeeds only with a same-cycle pop.
module xps2_fifo #(
  parameter  int unsigned FIFO_DEPTH = 8,
  localparam int unsigned PTR_W      = $clog2(FIFO_DEPTH),
  localparam int unsigned CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [7:0]       data_i,
  output logic [7:0]       head_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push_c;
  logic             do_pop_c;

  assign empty_o   = (count_q == '0);
  assign full_o    = (count_q == CNT_W'(FIFO_DEPTH));
  assign count_o   = count_q;
  assign head_o    = mem_q[rd_ptr_q];
  assign do_pop_c  = pop_i & ~empty_o;
  assign do_push_c = push_i & (~full_o | do_pop_c);

  always_ff @(posedge clk) begin
    if (do_push_c) mem_q[wr_ptr_q] <= data_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push_c) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop_c)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({do_push_c, do_pop_c})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/xps2_rx.sv
// Memory-mapped PS/2 keyboard receiver with byte FIFO and DATA/STATUS/COUNT registers.
// Optional make-code-only filtering is enabled by defining PS2_BREAK_FILTER_EN.
module xps2_rx
  import xps2_pkg::*;
#(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter int unsigned TIMEOUT_CYC = 5000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sel,
  input  logic              rw_req,
  input  logic              rw_rnw,
  input  logic [1:0]        rw_addr,
  input  logic [DATA_W-1:0] data_to_wr,
  output logic [DATA_W-1:0] data_to_rd,
  input  logic              ps2_clk,
  input  logic              ps2_data,
  output logic              irq
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC);

  logic             clk_s1_q, clk_s2_q, clk_d_q;
  logic             dat_s1_q, dat_s2_q;
  logic             fe_c;
  ps2_state_e       state_q;
  logic [2:0]       bitcnt_q;
  logic [7:0]       shift_q;
  logic             par_q;
  logic [TMO_W-1:0] tmo_q;
  logic             ovr_q, perr_q, ferr_q;
  logic             irq_q;

  logic             frame_end_c, par_ok_c, stop_ok_c, valid_c, push_c;
  logic             rd_c, wr_c, pop_c;
  logic [2:0]       clr_c;
  logic [7:0]       head;
  logic             full, empty;
  logic [CNT_W-1:0] count;
  logic             unused_c;

  // Two-flop synchronisers, preset to the idle-high bus level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_s1_q <= 1'b1;
      clk_s2_q <= 1'b1;
      clk_d_q  <= 1'b1;
      dat_s1_q <= 1'b1;
      dat_s2_q <= 1'b1;
    end else begin
      clk_s1_q <= ps2_clk;
      clk_s2_q <= clk_s1_q;
      clk_d_q  <= clk_s2_q;
      dat_s1_q <= ps2_data;
      dat_s2_q <= dat_s1_q;
    end
  end

  assign fe_c        = clk_d_q & ~clk_s2_q;
  assign frame_end_c = fe_c & (state_q == STOP);
  assign par_ok_c    = odd_parity_ok(shift_q, par_q);
  assign stop_ok_c   = dat_s2_q;
  assign valid_c     = frame_end_c & par_ok_c & stop_ok_c;

`ifdef PS2_BREAK_FILTER_EN
  logic brk_q;

  // A break prefix and the byte following it never reach the FIFO.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          brk_q <= 1'b0;
    else if (valid_c) brk_q <= brk_q ? 1'b0 : (shift_q == PS2_BREAK_CODE);
  end

  assign push_c = valid_c & ~brk_q & (shift_q != PS2_BREAK_CODE);
`else
  assign push_c = valid_c;
`endif

  // Frame FSM: steps on synchronised falling edges; a stalled frame is abandoned silently.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      bitcnt_q <= '0;
      shift_q  <= '0;
      par_q    <= 1'b0;
      tmo_q    <= '0;
    end else if (fe_c) begin
      tmo_q <= '0;
      case (state_q)
        IDLE: begin
          if (!dat_s2_q) begin
            state_q  <= DATA;
            bitcnt_q <= '0;
          end
        end
        DATA: begin
          shift_q  <= {dat_s2_q, shift_q[7:1]};
          bitcnt_q <= bitcnt_q + 3'd1;
          if (bitcnt_q == 3'd7) state_q <= PARITY;
        end
        PARITY: begin
          par_q   <= dat_s2_q;
          state_q <= STOP;
        end
        STOP:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end else if (state_q != IDLE) begin
      if (tmo_q == TMO_W'(TIMEOUT_CYC - 1)) begin
        state_q <= IDLE;
        tmo_q   <= '0;
      end else begin
        tmo_q <= tmo_q + TMO_W'(1);
      end
    end else begin
      tmo_q <= '0;
    end
  end

  assign rd_c  = rw_req & sel & rw_rnw;
  assign wr_c  = rw_req & sel & ~rw_rnw;
  assign pop_c = rd_c & (rw_addr == REG_DATA);
  assign clr_c = (wr_c && rw_addr == REG_STATUS) ? data_to_wr[ST_FERR:ST_OVR] : 3'b000;

  xps2_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push_c),
    .pop_i   (pop_c),
    .data_i  (shift_q),
    .head_o  (head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (count)
  );

  // Sticky error flags: a set in the same cycle as a clear wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovr_q  <= 1'b0;
      perr_q <= 1'b0;
      ferr_q <= 1'b0;
      irq_q  <= 1'b0;
    end else begin
      ovr_q  <= (ovr_q  & ~clr_c[0]) | (push_c & full & ~pop_c);
      perr_q <= (perr_q & ~clr_c[1]) | (frame_end_c & ~par_ok_c);
      ferr_q <= (ferr_q & ~clr_c[2]) | (frame_end_c & ~stop_ok_c);
      irq_q  <= ~empty;
    end
  end

  assign irq = irq_q;

  always_comb begin
    data_to_rd = '0;
    if (rd_c) begin
      case (rw_addr)
        REG_DATA:   if (!empty) data_to_rd = DATA_W'(head);
        REG_STATUS: data_to_rd = DATA_W'({ferr_q, perr_q, ovr_q, full, ~empty});
        REG_COUNT:  data_to_rd = DATA_W'(count);
        default:    data_to_rd = '0;
      endcase
    end
  end

  assign unused_c = ^{data_to_wr[DATA_W-1:ST_FERR+1], data_to_wr[ST_OVR-1:0]};

endmodule
